// File: rtl/contador_modn.sv
// Modulo-MODULUS up/down digit counter with clamped preset load, wrap/stop modes and ripple tc.
// count/expired/load_err are registered; zero/max/tc follow count and inputs combinationally.
module contador_modn #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 6,
  parameter bit WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             loadn,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             max,
  output logic             tc,
  output logic             expired,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS = 2^WIDTH is representable and every data value is in range.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic in_range;
  logic term;

  assign in_range = ({1'b0, data} < MOD_EXT);
  assign zero     = (count == '0);
  assign max      = (count == LAST);
  assign term     = up ? max : zero;
  assign tc       = en & term & ~expired;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count    <= '0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (!loadn) begin
        count    <= in_range ? data : LAST;
        load_err <= ~in_range;
        expired  <= 1'b0;
      end else if (en && !expired) begin
        if (!term) begin
          count <= up ? count + 1'b1 : count - 1'b1;
        end else if (WRAP) begin
          count <= up ? '0 : LAST;
        end else begin
          expired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/contador_modn.md
Name: contador_modn

Overview:
- Parametrised modulo-N up/down digit counter for the min:sec timer chain; successor to the fixed mod-6/mod-10 down-counters.
- Counts within 0..MODULUS-1 in either direction and loads a preset with range clamping.
- Offers wrap or stop-at-terminal mode and a ripple tc for cascading digits (sec units -> sec tens -> min units ...).
- A sticky expired flag reports timer completion in stop mode.

Parameters:
- WIDTH, 4: counter/data width in bits; requires 2^WIDTH >= MODULUS.
- MODULUS, 6: count range 0..MODULUS-1; legal range 2..2^WIDTH.
- WRAP, 1: 1 = wrap at terminal; 0 = stop at terminal and set expired.

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  asynchronous reset, active-high
- loadn  input  1  synchronous load, active-low
- data  input  WIDTH  preset value for load
- en  input  1  count enable, active-high (ripple input from lower digit)
- up  input  1  direction: 1 = increment, 0 = decrement
- count  output  WIDTH  current value (registered)
- zero  output  1  count == 0 (combinational)
- max  output  1  count == MODULUS-1 (combinational)
- tc  output  1  ripple carry/borrow to next digit (combinational)
- expired  output  1  sticky terminal flag, WRAP=0 only (registered)
- load_err  output  1  one-cycle pulse: last load was out of range (registered)

Behaviour:
- Reset (clear=1, asynchronous, any time including mid-count):
  - count=0, expired=0, load_err=0 immediately.
  - Held while clear=1; clk edges are ignored.
  - Deassertion takes effect at the next clk edge.
- Priority per rising clk edge: clear > load (loadn=0) > count (en=1) > hold.
- Load:
  - If data < MODULUS: count<=data, load_err<=0.
  - Otherwise: count<=MODULUS-1, load_err<=1 for one cycle.
  - Load always clears expired.
  - Load wins over simultaneous en; no count occurs that cycle.
- Terminal condition: term = up ? max : zero.
- Count (en=1, loadn=1):
  - Not term: count<=count+1 (up) or count-1 (down).
  - term and WRAP=1: count<=0 (up) or MODULUS-1 (down).
  - term and WRAP=0: count holds, expired<=1.
  - Once expired=1, further en does not change count.
  - Changing up while expired does not clear expired; only load or clear does.
- load_err returns to 0 on any edge without an out-of-range load.
- tc = en & term & ~expired:
  - WRAP=1: tc is high on every enabled terminal cycle.
  - WRAP=0: tc is high only on the first enabled terminal cycle, so a chained digit decrements exactly once.
- zero and max follow count combinationally; both reflect the reset value (zero=1, max=0) during clear.
- Arithmetic is WIDTH-bit. count never leaves 0..MODULUS-1, including via load.
- MODULUS=2^WIDTH is legal: max=all-ones, and a load can never trigger load_err.

Test Plan:
- Reset mid-count: MODULUS=6, up=0, count=3, pulse clear between edges -> count=0, zero=1, expired=0 immediately without waiting for clk.
- Down wrap, WRAP=1: load 2, en=1, up=0 for 4 cycles -> count 2,1,0,5,4; tc=1 only while count=0.
- Up wrap and direction switch: load 4, up=1, en=1 -> count 4,5,0; tc=1 at count=5. Then up=0 -> count 0,5; tc=1 at count=0.
- Range clamp: loadn=0, data=9, MODULUS=6 -> count=5, load_err=1 for exactly one cycle. Then data=3 -> count=3, load_err=0.
- Load vs enable: loadn=0, en=1, data=1 with count=4 -> count=1, no decrement that cycle. With WRAP=0, load also clears expired.
- Stop mode, WRAP=0: load 1, up=0, en=1 for 4 cycles -> count 1,0,0,0; expired=1 after the second edge. tc=1 for one cycle only; after that, en=1 gives tc=0.
